multi_cycle_main_fsm: RTL and testbench
=======================================

# multi_cycle_main_fsm

Main control state machine for the multi-cycle RV32I core. Each cycle it sequences the shared ALU, the instruction/data memory port and the register file by driving the 2-bit selectors of the datapath's 4-input multiplexers (ALU operand A, ALU operand B, result) and all write enables. It advances through fetch, decode, execute, memory and writeback steps according to the opcode latched in the instruction register. It sits beside the ALU decoder, which consumes `alu_op`.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state changes on the rising edge
- `resetn`  in  1  synchronous, active-low reset
- `opcode`  in  7  instr[6:0] from the instruction register
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory access complete (used only with `MEM_WAIT_EN`)
- `alu_src_a`  out  2  00 PC, 01 old PC, 10 rs1 data
- `alu_src_b`  out  2  00 rs2 data, 01 immediate, 10 constant 4
- `result_src`  out  2  00 ALUOut register, 01 memory data register, 10 ALU result
- `adr_src`  out  1  0 PC, 1 result
- `alu_op`  out  2  00 add, 01 subtract, 10 funct-decoded
- `ir_write`, `pc_write`, `reg_write`, `mem_write`  out  1 each  write enables
- `illegal_op`  out  1  single-cycle pulse on an unsupported opcode

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ.
- Outputs are Moore outputs decoded from the state. The one exception is `pc_write` in BEQ, which equals `zero`. Any output not listed for a state is 0.
- FETCH: adr_src=0, ir_write=1, a=00, b=10, alu_op=00, result_src=10, pc_write=1. Next state: DECODE.
- DECODE: a=01, b=01, alu_op=00. Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - any other opcode → FETCH, with `illegal_op`=1 for this cycle and no writes.
- MEMADR: a=10, b=01, alu_op=00. Next state: MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: result_src=00, adr_src=1. Next state: MEMWB.
- MEMWB: result_src=01, reg_write=1. Next state: FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1. Next state: FETCH.
- EXECR: a=10, b=00, alu_op=10. Next state: ALUWB.
- EXECI: a=10, b=01, alu_op=10. Next state: ALUWB.
- ALUWB: result_src=00, reg_write=1. Next state: FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1. Next state: ALUWB.
- BEQ: a=10, b=00, alu_op=01, result_src=00, pc_write=`zero`. Next state: FETCH.
- Reset:
  - While `resetn`=0, all write enables and `illegal_op` are forced to 0. Selectors hold their FETCH values.
  - After the first rising edge with `resetn`=0, the state is FETCH.
  - Reset asserted mid-instruction aborts the instruction. No partial write occurs in the reset cycle.
- An undefined state encoding returns to FETCH on the next edge.

## Timing
- Cycles per instruction, with no waits:
  - lw: 5
  - sw, R-type, I-type, jal: 4
  - beq: 3
- `opcode` is sampled only in DECODE and MEMADR.
- `zero` is used combinationally only in BEQ.
- The first FETCH occurs in the first cycle after `resetn` is released.

## Configuration
- `MEM_WAIT_EN` defined:
  - FETCH, MEMREAD and MEMWRITE each hold their state until `mem_ready`=1.
  - In FETCH, `ir_write` and `pc_write` assert only in the cycle where `mem_ready`=1.
  - In MEMWRITE, `mem_write` stays high through every wait cycle.
  - Each wait cycle adds 1 to that instruction's cycle count.
- `MEM_WAIT_EN` undefined: `mem_ready` is ignored, and every memory access completes in one cycle.

## Test plan
- Reset then lw (opcode 0000011) → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `reg_write`=1 only in cycle 5, with `result_src`=01.
- R-type (0110011), then sw (0100011) → EXECR shows a=10, b=00, alu_op=10. The sw shows `mem_write`=1 for exactly one cycle, with adr_src=1.
- beq with zero=1, then with zero=0 → `pc_write`=1 or 0 respectively in cycle 3. The next cycle is FETCH in both cases.
- jal (1101111) → JAL shows pc_write=1, a=01, b=10. It is followed by ALUWB with reg_write=1, for 4 cycles total.
- Opcode 1111111 → `illegal_op` pulses one cycle in DECODE, the FSM returns to FETCH, and no write enables assert.
- `resetn` dropped during MEMWRITE → `mem_write`=0 in that cycle and FETCH on the next edge.
- With `MEM_WAIT_EN`: `mem_ready` held low for 3 cycles in FETCH → `ir_write` stays 0 for 3 cycles and pulses once when `mem_ready` rises, giving lw 8 cycles.

Source files
------------

// File: rtl/multi_cycle_main_fsm_if.sv
// Control bundle between the multi-cycle main FSM (master) and the RV32I datapath (slave).
// Carries the opcode and status flags in, and the mux selectors and write enables out.
interface multi_cycle_main_fsm_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic [1:0] alu_op;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       illegal_op;

    modport master (
        input  opcode, zero, mem_ready,
        output alu_src_a, alu_src_b, result_src, adr_src, alu_op,
               ir_write, pc_write, reg_write, mem_write, illegal_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  alu_src_a, alu_src_b, result_src, adr_src, alu_op,
               ir_write, pc_write, reg_write, mem_write, illegal_op
    );
endinterface

// File: rtl/multi_cycle_main_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences ALU, memory port and register file.
// Optional MEM_WAIT_EN: FETCH, MEMREAD and MEMWRITE stall until mem_ready=1.
//
// state    | meaning
// ---------+----------------------------------------------------
// FETCH    | read instr at PC into IR, PC <= PC + 4
// DECODE   | read regs, ALUOut <= old PC + imm (branch target)
// MEMADR   | ALUOut <= rs1 + imm (load/store address)
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <= memory data register
// MEMWRITE | write rs2 to data memory at ALUOut
// EXECR    | ALUOut <= rs1 op rs2
// EXECI    | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// JAL      | PC <= ALUOut (target), ALUOut <= old PC + 4
// BEQ      | compare rs1 - rs2, PC <= ALUOut when zero
module multi_cycle_main_fsm (
    input  logic                   clk,
    input  logic                   resetn,
    multi_cycle_main_fsm_if.master bus
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    state_t     state, state_nxt;
    logic       mem_done;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic       adr_src, ir_write, pc_write, reg_write, mem_write, illegal_op;

`ifdef MEM_WAIT_EN
    assign mem_done = bus.mem_ready;
`else
    logic mem_ready_unused;
    assign mem_ready_unused = bus.mem_ready;
    assign mem_done         = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_FETCH;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = S_FETCH;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        adr_src    = 1'b0;
        alu_op     = 2'b00;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_done;
                pc_write   = mem_done;
                state_nxt  = mem_done ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECR;
                    OP_ITYPE:          state_nxt = S_EXECI;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_BEQ:            state_nxt = S_BEQ;
                    default: begin
                        state_nxt  = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nxt = (bus.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src   = 1'b1;
                state_nxt = mem_done ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_nxt = mem_done ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = bus.zero;
            end
            default: state_nxt = S_FETCH;
        endcase

        // Reset overrides everything so an aborted instruction never writes.
        if (!resetn) begin
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            adr_src    = 1'b0;
            alu_op     = 2'b00;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.result_src = result_src;
    assign bus.adr_src    = adr_src;
    assign bus.alu_op     = alu_op;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.reg_write  = reg_write;
    assign bus.mem_write  = mem_write;
    assign bus.illegal_op = illegal_op;

endmodule

// File: tb/tb_multi_cycle_main_fsm.sv
// Directed bench for multi_cycle_main_fsm: checks the full control word every cycle of each instruction.
// Control word = {a, b, result_src, adr_src, alu_op, ir, pc, reg_wr, mem_wr, illegal}.
module tb_multi_cycle_main_fsm;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_fail   = 0;

    multi_cycle_main_fsm_if bus ();

    multi_cycle_main_fsm dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [13:0] ctl_obs;
    assign ctl_obs = {bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.adr_src, bus.alu_op,
                      bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write, bus.illegal_op};

    function automatic logic [13:0] ctl(input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] rs, input logic adr,
                                        input logic [1:0] op, input logic ir, input logic pc,
                                        input logic rw, input logic mw, input logic ill);
        return {a, b, rs, adr, op, ir, pc, rw, mw, ill};
    endfunction

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s obs=%b exp=%b", tag, obs, expv);
        end
    endtask

    // Check the current cycle, then advance to 1 time unit after the next rising edge.
    task automatic cyc(input string tag, input logic [13:0] expv);
        chk(tag, ctl_obs, expv);
        @(posedge clk);
        #1;
    endtask

    logic [13:0] e_rst, e_fetch, e_fstall, e_decode, e_memadr, e_memread, e_memwb, e_memwrite;
    logic [13:0] e_execr, e_execi, e_aluwb, e_jal, e_beq1, e_beq0, e_ill;

    initial begin
        e_rst      = ctl(2'b00, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_fetch    = ctl(2'b00, 2'b10, 2'b10, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        e_fstall   = ctl(2'b00, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_decode   = ctl(2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_memadr   = ctl(2'b10, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_memread  = ctl(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_memwb    = ctl(2'b00, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        e_memwrite = ctl(2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        e_execr    = ctl(2'b10, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_execi    = ctl(2'b10, 2'b01, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_aluwb    = ctl(2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        e_jal      = ctl(2'b01, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        e_beq1     = ctl(2'b10, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        e_beq0     = ctl(2'b10, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e_ill      = ctl(2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        resetn     = 1'b0;
        bus.opcode = 7'b0000000;
        bus.zero   = 1'b0;
`ifdef MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`else
        bus.mem_ready = 1'b0;   // must be ignored in this build
`endif
        #1;
        chk("rst_held", ctl_obs, e_rst);
        @(posedge clk);
        #1;
        chk("rst_after_edge", ctl_obs, e_rst);
        resetn = 1'b1;
        #1;

        // lw: 5 cycles
        bus.opcode = 7'b0000011;
        cyc("lw_fetch",   e_fetch);
        cyc("lw_decode",  e_decode);
        cyc("lw_memadr",  e_memadr);
        cyc("lw_memread", e_memread);
        cyc("lw_memwb",   e_memwb);

        // R-type: 4 cycles
        bus.opcode = 7'b0110011;
        cyc("r_fetch",  e_fetch);
        cyc("r_decode", e_decode);
        cyc("r_execr",  e_execr);
        cyc("r_aluwb",  e_aluwb);

        // sw: 4 cycles, one mem_write cycle
        bus.opcode = 7'b0100011;
        cyc("sw_fetch",    e_fetch);
        cyc("sw_decode",   e_decode);
        cyc("sw_memadr",   e_memadr);
        cyc("sw_memwrite", e_memwrite);

        // beq taken then not taken; zero high outside BEQ must not matter
        bus.opcode = 7'b1100011;
        bus.zero   = 1'b1;
        cyc("beq1_fetch",  e_fetch);
        cyc("beq1_decode", e_decode);
        cyc("beq1_beq",    e_beq1);
        cyc("beq0_fetch",  e_fetch);
        bus.zero = 1'b0;
        cyc("beq0_decode", e_decode);
        cyc("beq0_beq",    e_beq0);

        // jal with zero high
        bus.opcode = 7'b1101111;
        bus.zero   = 1'b1;
        cyc("jal_fetch",  e_fetch);
        cyc("jal_decode", e_decode);
        cyc("jal_jal",    e_jal);
        cyc("jal_aluwb",  e_aluwb);
        bus.zero = 1'b0;

        // illegal opcode: pulse in DECODE, straight back to FETCH
        bus.opcode = 7'b1111111;
        cyc("ill_fetch",  e_fetch);
        cyc("ill_decode", e_ill);

        // I-type
        bus.opcode = 7'b0010011;
        cyc("i_fetch",  e_fetch);
        cyc("i_decode", e_decode);
        cyc("i_execi",  e_execi);
        cyc("i_aluwb",  e_aluwb);

        // reset asserted during MEMWRITE
        bus.opcode = 7'b0100011;
        cyc("swr_fetch",  e_fetch);
        cyc("swr_decode", e_decode);
        cyc("swr_memadr", e_memadr);
        resetn = 1'b0;
        #1;
        chk("swr_rst_memwrite", ctl_obs, e_rst);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        bus.opcode = 7'b0000011;
        cyc("swr_refetch", e_fetch);
        cyc("post_rst_decode", e_decode);
        cyc("post_rst_memadr", e_memadr);
        cyc("post_rst_memread", e_memread);
        cyc("post_rst_memwb", e_memwb);

`ifdef MEM_WAIT_EN
        // lw with mem_ready low for 3 FETCH cycles: 8 cycles total
        bus.mem_ready = 1'b0;
        #1;
        cyc("wait_f0", e_fstall);
        cyc("wait_f1", e_fstall);
        cyc("wait_f2", e_fstall);
        bus.mem_ready = 1'b1;
        #1;
        cyc("wait_f3",      e_fetch);
        cyc("wait_decode",  e_decode);
        cyc("wait_memadr",  e_memadr);
        cyc("wait_memread", e_memread);
        cyc("wait_memwb",   e_memwb);
        cyc("wait_next",    e_fetch);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
